logic_unit_arbiter: RTL

- Shares one bitwise logic unit (AND/OR/XOR/NOT, the primitive gates of the CPU datapath) among NUM_REQ requesters.
- Round-robin arbitration, valid/ready request handshake per requester, one registered response channel tagged with requester ID.
- Sits between decode/microsequencer clients and the logic datapath; the first sequential consumer of the gate-level blocks.

---
 rtl/logic_unit_arbiter_pkg.sv | 19 +
 rtl/logic_unit_arbiter_if.sv | 32 +++
 rtl/logic_unit_arbiter_rr_priority_pick.sv | 35 +++
 rtl/logic_unit_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic-unit arbiter: opcode encodings and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package logic_unit_arbiter_pkg;

  // Opcodes carried on each requester's 2-bit op field.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  // Arbiter control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the requesters/consumer and the logic-unit arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready per requester, rsp_valid/rsp_ready on the response.
// Ports: master = requester/consumer side, slave = arbiter side.
//   req_valid[NUM_REQ], req_ready[NUM_REQ], req_op[2*NUM_REQ],
//   req_a/req_b[WIDTH*NUM_REQ] (requester i in slice i), rsp_valid, rsp_ready,
//   rsp_y[WIDTH], rsp_id[ID_W].
interface logic_unit_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_y;
  logic [ID_W-1:0]          rsp_id;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_id
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_id
  );
endinterface

// File: rtl/logic_unit_arbiter_rr_priority_pick.sv
// Round-robin picker: first set bit of req scanning upward from last_grant+1 with wrap.
// Latency: combinational.
// Backpressure: none; grant is one-hot or zero, any flags a winner.
// Ports: req[NUM_REQ], last_grant[ID_W] in; grant[NUM_REQ] one-hot, winner[ID_W], any out.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  int idx;

  always_comb begin
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    // Offset 1 first, offset NUM_REQ (last_grant itself) last.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any && req[ID_W'(idx)]) begin
        any                 = 1'b1;
        grant[ID_W'(idx)]   = 1'b1;
        winner              = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one AND/OR/XOR/NOT unit among NUM_REQ requesters with round-robin grant.
// Latency: request handshake at cycle T -> rsp_valid at T+2; one op per 3 cycles peak.
// Backpressure: req_ready only in IDLE; rsp_y/rsp_id held in RESP until rsp_ready.
// Ports: clk, rst_n (synchronous, active-low), bus (logic_unit_arbiter_if.slave);
//   op_count[16] (saturating completed-response count) only when LOGIC_ARB_STATS_EN is defined.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2   // must equal clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_arbiter_if.slave  bus
`ifdef LOGIC_ARB_STATS_EN
  ,
  output logic [15:0]          op_count
`endif
);

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, y_q, y_d;
  logic [ID_W-1:0]    id_q, rsp_id_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               take;

  logic [1:0]         op_sel;
  logic [WIDTH-1:0]   a_sel, b_sel;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .winner     (pick_idx),
    .any        (pick_any)
  );

  // One-hot grant makes this an AND-OR mux of the winner's operands.
  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        op_sel = op_sel | bus.req_op[2*i +: 2];
        a_sel  = a_sel  | bus.req_a[WIDTH*i +: WIDTH];
        b_sel  = b_sel  | bus.req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Next state and request-side outputs. req_ready is suppressed while
  // rst_n is low so no requester sees an accept that reset then discards.
  always_comb begin
    state_d     = state_q;
    req_ready_c = '0;
    take        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rst_n) begin
          req_ready_c = pick_grant;
          if (pick_any) begin
            take    = 1'b1;
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    y_d = '0;
    unique case (op_q)
      OP_AND: y_d = a_q & b_q;
      OP_OR:  y_d = a_q | b_q;
      OP_XOR: y_d = a_q ^ b_q;
      OP_NOT: y_d = ~a_q;
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      y_q          <= '0;
      rsp_id_q     <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_q         <= op_sel;
        a_q          <= a_sel;
        b_q          <= b_sel;
        id_q         <= pick_idx;
        last_grant_q <= pick_idx;
      end
      if (state_q == S_EXEC) begin
        y_q      <= y_d;
        rsp_id_q <= id_q;
      end
    end
  end

`ifdef LOGIC_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (state_q == S_RESP && bus.rsp_ready && op_count != 16'hFFFF) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_y     = y_q;
  assign bus.rsp_id    = rsp_id_q;

endmodule
